alu_muldiv_seq: RTL and testbench

Command sequencer that drives the 8-bit ALU's operand and `funct` inputs to run a full 16-bit multiply or divide/modulus and return the assembled result. It sits between a request/response client (control unit or test harness) and the ALU. It issues the compute code, then the high-byte and low-byte read codes, and packs the two captured bytes into one 16-bit response. It provides the initiator side of the ALU's funct-code protocol.

---
 rtl/alu_muldiv_seq_if.sv | 28 ++
 rtl/alu_muldiv_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: bundles the request/response handshake and the ALU
// operand/funct bus of the 16-bit multiply/divmod sequencer.
// master = environment side (client plus ALU), slave = the sequencer.
interface alu_muldiv_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_op;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_funct;
   logic [7:0]  alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
      input  req_ready, alu_a, alu_b, alu_funct, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
      output req_ready, alu_a, alu_b, alu_funct, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: drives the 8-bit ALU through its funct-code protocol
// (compute, read high byte, read low byte) and returns one 16-bit result.
// Optional macro ALU_SEQ_DIVZERO_EN: divmod by zero short-circuits to an
// error response (rsp_data=16'hFFFF, rsp_err=1) without touching the ALU.
module alu_muldiv_seq #(
   parameter int HOLD = 1
) (
   input logic               clk,
   input logic               rst,
   alu_muldiv_seq_if.slave   bus
);

   localparam logic [2:0] F_PARK  = 3'b000;
   localparam logic [2:0] F_MUL   = 3'b100;
   localparam logic [2:0] F_DIV   = 3'b101;
   localparam logic [2:0] F_RD_HI = 3'b110;
   localparam logic [2:0] F_RD_LO = 3'b111;

   localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      RD_HI = 3'd2,
      RD_LO = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        op_q;
   logic [7:0]  hi_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [15:0] rsp_data_q;
   logic [7:0]  alu_a_q;
   logic [7:0]  alu_b_q;
   logic [2:0]  alu_funct_q;
   logic        accept_d;
   logic        hold_done_d;
   logic [3:0]  cnt_d;

   assign accept_d    = (state_q == IDLE) && bus.req_valid && req_ready_q;
   assign hold_done_d = (cnt_q == 4'd0);
   assign cnt_d       = hold_done_d ? CNT_LOAD : (cnt_q - 4'd1);

`ifdef ALU_SEQ_DIVZERO_EN
   logic rsp_err_q;
   logic divzero_d;

   assign divzero_d = bus.req_op && (bus.req_b == 8'd0);

   // Sequencer FSM with registered outputs; divide-by-zero bypasses the ALU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         op_q        <= 1'b0;
         hi_q        <= 8'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'd0;
         rsp_err_q   <= 1'b0;
         alu_a_q     <= 8'd0;
         alu_b_q     <= 8'd0;
         alu_funct_q <= F_PARK;
      end else begin
         case (state_q)
            IDLE: begin
               alu_funct_q <= F_PARK;
               req_ready_q <= 1'b1;
               if (accept_d) begin
                  req_ready_q <= 1'b0;
                  alu_a_q     <= bus.req_a;
                  alu_b_q     <= bus.req_b;
                  op_q        <= bus.req_op;
                  cnt_q       <= CNT_LOAD;
                  if (divzero_d) begin
                     rsp_data_q  <= 16'hFFFF;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     alu_funct_q <= bus.req_op ? F_DIV : F_MUL;
                     state_q     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt_q <= cnt_d;
               if (hold_done_d) begin
                  alu_funct_q <= F_RD_HI;
                  state_q     <= RD_HI;
               end
            end
            RD_HI: begin
               cnt_q <= cnt_d;
               if (hold_done_d) begin
                  hi_q        <= bus.alu_result;
                  alu_funct_q <= F_RD_LO;
                  state_q     <= RD_LO;
               end
            end
            RD_LO: begin
               cnt_q <= cnt_d;
               if (hold_done_d) begin
                  rsp_data_q  <= {hi_q, bus.alu_result};
                  rsp_valid_q <= 1'b1;
                  alu_funct_q <= F_PARK;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               alu_funct_q <= F_PARK;
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               alu_funct_q <= F_PARK;
            end
         endcase
      end
   end

   assign bus.rsp_err = rsp_err_q;
`else
   // Sequencer FSM with registered outputs: park, compute, read hi, read lo.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         op_q        <= 1'b0;
         hi_q        <= 8'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'd0;
         alu_a_q     <= 8'd0;
         alu_b_q     <= 8'd0;
         alu_funct_q <= F_PARK;
      end else begin
         case (state_q)
            IDLE: begin
               alu_funct_q <= F_PARK;
               req_ready_q <= 1'b1;
               if (accept_d) begin
                  req_ready_q <= 1'b0;
                  alu_a_q     <= bus.req_a;
                  alu_b_q     <= bus.req_b;
                  op_q        <= bus.req_op;
                  cnt_q       <= CNT_LOAD;
                  alu_funct_q <= bus.req_op ? F_DIV : F_MUL;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q <= cnt_d;
               if (hold_done_d) begin
                  alu_funct_q <= F_RD_HI;
                  state_q     <= RD_HI;
               end
            end
            RD_HI: begin
               cnt_q <= cnt_d;
               if (hold_done_d) begin
                  hi_q        <= bus.alu_result;
                  alu_funct_q <= F_RD_LO;
                  state_q     <= RD_LO;
               end
            end
            RD_LO: begin
               cnt_q <= cnt_d;
               if (hold_done_d) begin
                  rsp_data_q  <= {hi_q, bus.alu_result};
                  rsp_valid_q <= 1'b1;
                  alu_funct_q <= F_PARK;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               alu_funct_q <= F_PARK;
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               alu_funct_q <= F_PARK;
            end
         endcase
      end
   end

   // Without the zero check there is no error condition to report.
   assign bus.rsp_err = 1'b0;

   // op_q only matters for the compute code chosen at accept time.
   logic unused_op;
   assign unused_op = op_q;
`endif

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_funct = alu_funct_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed checks of the multiply/divmod sequencer with
// HOLD=1 and HOLD=3 instances, each driving a small behavioural ALU.
module tb_alu_muldiv_seq;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   alu_muldiv_seq_if if1 ();
   alu_muldiv_seq_if if3 ();

   alu_muldiv_seq #(.HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   alu_muldiv_seq #(.HOLD(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: compute codes latch a 16-bit result, read codes return a byte.
   logic [15:0] res1_q;
   logic [15:0] res3_q;

   always @(posedge clk) begin
      if (if1.alu_funct == 3'b100)
         res1_q <= 16'(if1.alu_a) * 16'(if1.alu_b);
      else if (if1.alu_funct == 3'b101)
         res1_q <= (if1.alu_b != 8'd0) ? {8'(if1.alu_a % if1.alu_b), 8'(if1.alu_a / if1.alu_b)} : 16'h0000;
      if (if3.alu_funct == 3'b100)
         res3_q <= 16'(if3.alu_a) * 16'(if3.alu_b);
      else if (if3.alu_funct == 3'b101)
         res3_q <= (if3.alu_b != 8'd0) ? {8'(if3.alu_a % if3.alu_b), 8'(if3.alu_a / if3.alu_b)} : 16'h0000;
   end

   assign if1.alu_result = (if1.alu_funct == 3'b110) ? res1_q[15:8] :
                           (if1.alu_funct == 3'b111) ? res1_q[7:0]  : 8'h00;
   assign if3.alu_result = (if3.alu_funct == 3'b110) ? res3_q[15:8] :
                           (if3.alu_funct == 3'b111) ? res3_q[7:0]  : 8'h00;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst = 1'b1;
      res1_q = 16'h0;
      res3_q = 16'h0;
      if1.req_valid = 1'b0; if1.req_op = 1'b0; if1.req_a = 8'd0; if1.req_b = 8'd0; if1.rsp_ready = 1'b0;
      if3.req_valid = 1'b0; if3.req_op = 1'b0; if3.req_a = 8'd0; if3.req_b = 8'd0; if3.rsp_ready = 1'b0;
      tick(2);

      // Reset state
      chk("rst_req_ready", 16'(if1.req_ready), 16'd0);
      chk("rst_rsp_valid", 16'(if1.rsp_valid), 16'd0);
      chk("rst_rsp_data",  if1.rsp_data, 16'h0000);
      chk("rst_rsp_err",   16'(if1.rsp_err), 16'd0);
      chk("rst_funct",     16'(if1.alu_funct), 16'd0);
      chk("rst_alu_ab",    {if1.alu_a, if1.alu_b}, 16'h0000);
      rst = 1'b0;
      tick(1);
      chk("idle_req_ready", 16'(if1.req_ready), 16'd1);
      chk("idle_funct",     16'(if1.alu_funct), 16'd0);

      // HOLD=1 multiply 200*200, funct sequence 100,110,111,000
      if1.req_valid = 1'b1; if1.req_op = 1'b0; if1.req_a = 8'd200; if1.req_b = 8'd200;
      tick(1);
      if1.req_valid = 1'b0;
      chk("mul_c1_funct",     16'(if1.alu_funct), 16'b100);
      chk("mul_c1_req_ready", 16'(if1.req_ready), 16'd0);
      chk("mul_c1_alu_ab",    {if1.alu_a, if1.alu_b}, {8'd200, 8'd200});
      tick(1);
      chk("mul_c2_funct", 16'(if1.alu_funct), 16'b110);
      tick(1);
      chk("mul_c3_funct",     16'(if1.alu_funct), 16'b111);
      chk("mul_c3_rsp_valid", 16'(if1.rsp_valid), 16'd0);
      tick(1);
      chk("mul_c4_rsp_valid", 16'(if1.rsp_valid), 16'd1);
      chk("mul_c4_rsp_data",  if1.rsp_data, 16'h9C40);
      chk("mul_c4_rsp_err",   16'(if1.rsp_err), 16'd0);
      chk("mul_c4_funct",     16'(if1.alu_funct), 16'b000);

      // Backpressure: response held for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("bp_rsp_valid", 16'(if1.rsp_valid), 16'd1);
         chk("bp_rsp_data",  if1.rsp_data, 16'h9C40);
         chk("bp_req_ready", 16'(if1.req_ready), 16'd0);
      end
      if1.rsp_ready = 1'b1;
      tick(1);
      if1.rsp_ready = 1'b0;
      chk("bp_release_rsp_valid", 16'(if1.rsp_valid), 16'd0);
      chk("bp_release_req_ready", 16'(if1.req_ready), 16'd1);

      // HOLD=1 divmod 200/7 with early rsp_ready and a request change ignored mid-op
      if1.rsp_ready = 1'b1;
      if1.req_valid = 1'b1; if1.req_op = 1'b1; if1.req_a = 8'd200; if1.req_b = 8'd7;
      tick(1);
      if1.req_a = 8'd55;
      chk("div_c1_funct", 16'(if1.alu_funct), 16'b101);
      chk("div_c1_alu_a", 16'(if1.alu_a), 16'd200);
      tick(1);
      chk("div_c2_funct", 16'(if1.alu_funct), 16'b110);
      chk("div_c2_alu_a", 16'(if1.alu_a), 16'd200);
      if1.req_valid = 1'b0;
      tick(1);
      chk("div_c3_funct",     16'(if1.alu_funct), 16'b111);
      chk("div_c3_rsp_valid", 16'(if1.rsp_valid), 16'd0);
      tick(1);
      chk("div_c4_rsp_valid", 16'(if1.rsp_valid), 16'd1);
      chk("div_c4_rsp_data",  if1.rsp_data, 16'h041C);
      tick(1);
      if1.rsp_ready = 1'b0;
      chk("div_consumed_rsp_valid", 16'(if1.rsp_valid), 16'd0);
      chk("div_consumed_req_ready", 16'(if1.req_ready), 16'd1);

      // Reset during RD_HI discards the operation
      if1.req_valid = 1'b1; if1.req_op = 1'b0; if1.req_a = 8'd5; if1.req_b = 8'd5;
      tick(1);
      if1.req_valid = 1'b0;
      tick(1);
      chk("rsthi_funct_before", 16'(if1.alu_funct), 16'b110);
      rst = 1'b1;
      #1;
      chk("rsthi_funct",     16'(if1.alu_funct), 16'b000);
      chk("rsthi_alu_ab",    {if1.alu_a, if1.alu_b}, 16'h0000);
      chk("rsthi_req_ready", 16'(if1.req_ready), 16'd0);
      chk("rsthi_rsp_valid", 16'(if1.rsp_valid), 16'd0);
      tick(1);
      rst = 1'b0;
      if1.rsp_ready = 1'b1;
      tick(4);
      chk("rsthi_no_rsp", 16'(if1.rsp_valid), 16'd0);
      if1.rsp_ready = 1'b0;
      chk("rsthi_idle_ready", 16'(if1.req_ready), 16'd1);
      if1.req_valid = 1'b1; if1.req_op = 1'b0; if1.req_a = 8'd2; if1.req_b = 8'd3;
      tick(1);
      if1.req_valid = 1'b0;
      tick(3);
      chk("after_rst_rsp_valid", 16'(if1.rsp_valid), 16'd1);
      chk("after_rst_rsp_data",  if1.rsp_data, 16'h0006);
      if1.rsp_ready = 1'b1;
      tick(1);
      if1.rsp_ready = 1'b0;
      chk("after_rst_consumed", 16'(if1.rsp_valid), 16'd0);

      // Divmod by zero
      if1.req_valid = 1'b1; if1.req_op = 1'b1; if1.req_a = 8'd9; if1.req_b = 8'd0;
      tick(1);
      if1.req_valid = 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
      chk("dz_rsp_valid", 16'(if1.rsp_valid), 16'd1);
      chk("dz_rsp_data",  if1.rsp_data, 16'hFFFF);
      chk("dz_rsp_err",   16'(if1.rsp_err), 16'd1);
      chk("dz_funct",     16'(if1.alu_funct), 16'b000);
      tick(1);
      chk("dz_funct_held", 16'(if1.alu_funct), 16'b000);
      if1.rsp_ready = 1'b1;
      tick(1);
      if1.rsp_ready = 1'b0;
      chk("dz_err_cleared", 16'(if1.rsp_err), 16'd0);
      chk("dz_rsp_cleared", 16'(if1.rsp_valid), 16'd0);
`else
      chk("dz_c1_funct", 16'(if1.alu_funct), 16'b101);
      tick(3);
      chk("dz_rsp_valid", 16'(if1.rsp_valid), 16'd1);
      chk("dz_rsp_err",   16'(if1.rsp_err), 16'd0);
      if1.rsp_ready = 1'b1;
      tick(1);
      if1.rsp_ready = 1'b0;
      chk("dz_rsp_cleared", 16'(if1.rsp_valid), 16'd0);
`endif

      // HOLD=3 multiply 15*17, each code held 3 cycles, response after 10 edges
      chk("h3_req_ready", 16'(if3.req_ready), 16'd1);
      if3.req_valid = 1'b1; if3.req_op = 1'b0; if3.req_a = 8'd15; if3.req_b = 8'd17;
      tick(1);
      if3.req_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         chk("h3_funct", 16'(if3.alu_funct),
             (k <= 3) ? 16'b100 : ((k <= 6) ? 16'b110 : 16'b111));
         chk("h3_rsp_valid_low", 16'(if3.rsp_valid), 16'd0);
         tick(1);
      end
      chk("h3_rsp_valid", 16'(if3.rsp_valid), 16'd1);
      chk("h3_rsp_data",  if3.rsp_data, 16'h00FF);
      chk("h3_funct_park", 16'(if3.alu_funct), 16'b000);
      if3.rsp_ready = 1'b1;
      tick(1);
      if3.rsp_ready = 1'b0;
      chk("h3_consumed", 16'(if3.rsp_valid), 16'd0);
      tick(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
